// File: rtl/cam_exposure_ctrl.sv
// Auto-exposure controller: compares each frame average against a target window and issues one
// exposure-register write per frame, then waits SETTLE_FRAMES V_SYNC falls. Option: CAM_AE_PROP_EN.
module cam_exposure_ctrl #(
  parameter int              EXP_W         = 16,
  parameter logic [EXP_W-1:0] EXP_INIT     = 16'h0200,
  parameter logic [EXP_W-1:0] EXP_MIN      = 16'h0010,
  parameter logic [EXP_W-1:0] EXP_MAX      = 16'h0FFF,
  parameter logic [7:0]      EXP_ADDR      = 8'h10,
  parameter logic [7:0]      TARGET        = 8'd128,
  parameter logic [7:0]      TOL           = 8'd8,
  parameter logic [EXP_W-1:0] STEP         = 16'd32,
`ifdef CAM_AE_PROP_EN
  parameter int              PROP_SHIFT    = 2,
`endif
  parameter int              SETTLE_FRAMES = 2
) (
  input  logic             VGA_CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             V_SYNC,
  input  logic             avg_valid,
  input  logic [7:0]       avg,
  output logic             cfg_req,
  output logic [7:0]       cfg_addr,
  output logic [EXP_W-1:0] cfg_data,
  input  logic             cfg_ack,
  output logic [EXP_W-1:0] exposure,
  output logic             locked,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  logic [1:0]       state;
  logic [7:0]       avg_q;
  logic [7:0]       settle_cnt;
  logic             vs_prev;
  logic             vs_fall;
  logic [8:0]       err;
  logic [8:0]       err_neg_val;
  logic             err_neg;
  logic [7:0]       err_mag;
  logic             in_window;
  logic [EXP_W-1:0] step;
  logic [EXP_W:0]   sum;
  logic [EXP_W-1:0] nxt;

  assign cfg_addr = EXP_ADDR;
  assign busy     = (state != S_IDLE);
  assign vs_fall  = vs_prev & ~V_SYNC;

  // Two's-complement error of the captured average; magnitude fits 8 bits (max 128).
  assign err         = {1'b0, avg_q} - {1'b0, TARGET};
  assign err_neg     = err[8];
  assign err_neg_val = 9'd0 - err;
  assign err_mag     = err_neg ? err_neg_val[7:0] : err[7:0];
  assign in_window   = (err_mag <= TOL);

`ifdef CAM_AE_PROP_EN
  logic [7:0] prop;
  assign prop = err_mag >> PROP_SHIFT;
  always_comb begin
    step = STEP;
    if (prop == 8'd0)
      step = EXP_W'(1);
    else if (EXP_W'(prop) < STEP)
      step = EXP_W'(prop);
  end
`else
  assign step = STEP;
`endif

  // One extra bit catches both overflow of the add and borrow of the subtract before clamping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nxt = exposure;
    sum = err_neg ? ({1'b0, exposure} + {1'b0, step})
                  : ({1'b0, exposure} - {1'b0, step});
    if (!err_neg && sum[EXP_W])
      nxt = EXP_MIN;
    else if (sum < {1'b0, EXP_MIN})
      nxt = EXP_MIN;
    else if (sum > {1'b0, EXP_MAX})
      nxt = EXP_MAX;
    else
      nxt = sum[EXP_W-1:0];
  end

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      avg_q      <= 8'd0;
      settle_cnt <= 8'd0;
      vs_prev    <= 1'b1;
      cfg_req    <= 1'b0;
      cfg_data   <= EXP_INIT;
      exposure   <= EXP_INIT;
      locked     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge register values.
      vs_prev <= V_SYNC;
      case (state)
        S_IDLE: begin
          if (avg_valid && enable) begin
            avg_q <= avg;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (in_window) begin
            locked <= 1'b1;
            state  <= S_IDLE;
          end else begin
            locked <= 1'b0;
            if (nxt == exposure) begin
              state <= S_IDLE;
            end else begin
              cfg_data <= nxt;
              cfg_req  <= 1'b1;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // Once a write is requested it always completes; disable only skips the settle wait.
          if (cfg_ack) begin
            cfg_req    <= 1'b0;
            exposure   <= cfg_data;
            settle_cnt <= 8'd0;
            state      <= enable ? S_SETTLE : S_IDLE;
          end
        end
        default: begin
          if (!enable || settle_cnt == 8'(SETTLE_FRAMES))
            state <= S_IDLE;
          else if (vs_fall)
            settle_cnt <= settle_cnt + 8'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_exposure_ctrl.sv
// Self-checking bench for cam_exposure_ctrl: directed steps, a reference model, and a queue of
// expected cfg_data values pushed when an average is driven and popped when cfg_req appears.
module tb_cam_exposure_ctrl;

  localparam logic [15:0] INIT_V = 16'h0200;
  localparam logic [15:0] MIN_V  = 16'h0010;
  localparam logic [15:0] MAX_V  = 16'h0FFF;
  localparam int          TOL_V  = 8;

  logic        VGA_CLK = 1'b0;
  logic        RST;
  logic        enable;
  logic        V_SYNC;
  logic        avg_valid;
  logic [7:0]  avg;
  logic        cfg_req;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_ack;
  logic [15:0] exposure;
  logic        locked;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_exp;
  logic        m_locked;
  logic [15:0] exp_q[$];

  cam_exposure_ctrl dut (
    .VGA_CLK  (VGA_CLK),
    .RST      (RST),
    .enable   (enable),
    .V_SYNC   (V_SYNC),
    .avg_valid(avg_valid),
    .avg      (avg),
    .cfg_req  (cfg_req),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_ack  (cfg_ack),
    .exposure (exposure),
    .locked   (locked),
    .busy     (busy)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model of one evaluation: returns magnitude of error and the clamped next exposure.
  task automatic model(input logic [15:0] e, input logic [7:0] a, output int mag,
                       output logic [15:0] nxt);
    int err;
    int st;
    int n;
    err = int'(a) - 128;
    mag = (err < 0) ? -err : err;
`ifdef CAM_AE_PROP_EN
    st = mag / 4;
    if (st > 32) st = 32;
    if (st < 1) st = 1;
`else
    st = 32;
`endif
    n = (err < 0) ? int'(e) + st : int'(e) - st;
    if (n > int'(MAX_V)) n = int'(MAX_V);
    if (n < int'(MIN_V)) n = int'(MIN_V);
    nxt = 16'(n);
  endtask

  task automatic frame(input bit probe);
    V_SYNC = 1'b0;
    if (probe) begin
      avg = 8'd0;
      avg_valid = 1'b1;
    end
    tick();
    avg_valid = 1'b0;
    tick();
    V_SYNC = 1'b1;
    tick();
    tick();
  endtask

  // One full transaction: drive an average, follow the controller through EVAL/WRITE/SETTLE.
  task automatic ae_step(input logic [7:0] a, input int ack_dly, input bit probe, input bit drop_en);
    int          mag;
    logic [15:0] nxt;
    logic [15:0] exp_d;
    bit          wr;
    model(m_exp, a, mag, nxt);
    m_locked = (mag <= TOL_V);
    wr = (mag > TOL_V) && (nxt != m_exp);
    if (wr) exp_q.push_back(nxt);
    avg = a;
    avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    check("eval_busy", busy, 1);
    check("eval_no_req", cfg_req, 0);
    tick();
    check("locked", locked, m_locked);
    if (wr) begin
      exp_d = exp_q.pop_front();
      check("req_rise", cfg_req, 1);
      check("cfg_addr", cfg_addr, 32'h10);
      check("cfg_data", cfg_data, exp_d);
      if (drop_en) enable = 1'b0;
      for (int k = 0; k < ack_dly; k++) begin
        tick();
        check("req_hold", cfg_req, 1);
        check("data_hold", cfg_data, exp_d);
      end
      cfg_ack = 1'b1;
      if (probe) begin
        avg = 8'd0;
        avg_valid = 1'b1;
      end
      tick();
      cfg_ack = 1'b0;
      avg_valid = 1'b0;
      m_exp = exp_d;
      check("req_drop", cfg_req, 0);
      check("exposure_upd", exposure, m_exp);
      if (drop_en) begin
        check("no_settle", busy, 0);
        tick();
        check("idle_after_drop", busy, 0);
      end else begin
        check("settle_busy", busy, 1);
        frame(probe);
        check("settle_mid", busy, 1);
        frame(probe);
        check("settle_done", busy, 0);
        tick();
        check("no_req_after_settle", cfg_req, 0);
        check("idle_after_settle", busy, 0);
      end
    end else begin
      check("no_req", cfg_req, 0);
      check("idle", busy, 0);
      check("exposure_hold", exposure, m_exp);
    end
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    #1;
    check("rst_req", cfg_req, 0);
    check("rst_exposure", exposure, INIT_V);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_data", cfg_data, INIT_V);
    tick();
    RST = 1'b0;
    m_exp = INIT_V;
    m_locked = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b1;
    enable = 1'b1;
    V_SYNC = 1'b1;
    avg_valid = 1'b0;
    avg = 8'd0;
    cfg_ack = 1'b0;
    m_exp = INIT_V;
    m_locked = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    check("por_req", cfg_req, 0);
    check("por_exposure", exposure, INIT_V);
    check("por_cfg_data", cfg_data, INIT_V);
    check("por_locked", locked, 0);
    check("por_busy", busy, 0);
    check("por_addr", cfg_addr, 32'h10);

    // Below-target average with settle-time probes and an ack-coincident avg_valid.
    ae_step(8'd60, 3, 1'b1, 1'b0);

    // In-window average locks, then a reset while idle clears locked.
    ae_step(8'd130, 0, 1'b0, 1'b0);
    reset_pulse();

    // Reset asserted mid-WRITE drops the request within the same cycle.
    avg = 8'd60;
    avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    tick();
    check("pre_rst_req", cfg_req, 1);
    #2;
    reset_pulse();

    // Locked, then an out-of-window average from the reset exposure.
    ae_step(8'd130, 0, 1'b0, 1'b0);
    ae_step(8'd100, 1, 1'b0, 1'b0);

    // Above-target average from the reset value: step size depends on the build option.
    reset_pulse();
    ae_step(8'd200, 2, 1'b0, 1'b0);
`ifdef CAM_AE_PROP_EN
    check("prop_step_exposure", exposure, 32'h01EE);
`else
    check("fixed_step_exposure", exposure, 32'h01E0);
`endif

    // Disable while the request is pending: handshake completes, no settle wait.
    ae_step(8'd60, 2, 1'b0, 1'b1);
    enable = 1'b1;

    // Disabled in IDLE: averages are ignored.
    enable = 1'b0;
    avg = 8'd0;
    avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    check("dis_idle_busy", busy, 0);
    tick();
    check("dis_idle_req", cfg_req, 0);
    enable = 1'b1;

    // Disable during EVAL returns to IDLE without a write and keeps locked.
    ae_step(8'd128, 0, 1'b0, 1'b0);
    avg = 8'd0;
    avg_valid = 1'b1;
    tick();
    avg_valid = 1'b0;
    enable = 1'b0;
    tick();
    check("dis_eval_busy", busy, 0);
    check("dis_eval_req", cfg_req, 0);
    check("dis_eval_locked", locked, 1);
    enable = 1'b1;

    // Drive exposure to the lower bound, then all the way to the upper bound.
    reset_pulse();
    for (int i = 0; i < 60 && m_exp != MIN_V; i++) ae_step(8'd255, i % 3, 1'b0, 1'b0);
    ae_step(8'd255, 0, 1'b0, 1'b0);
    check("sat_low", exposure, MIN_V);
    for (int i = 0; i < 300 && m_exp != MAX_V; i++) ae_step(8'd10, i % 3, 1'b0, 1'b0);
    ae_step(8'd10, 0, 1'b0, 1'b0);
    check("sat_high", exposure, MAX_V);
    check("sat_high_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
